// File: rtl/keypad_scan_4x4.sv
// 4x4 passive key-matrix scanner: row multiplexing, 2-flop column sync, per-scan debounce, one strobe per press.
// Optional auto-repeat of the held key is built only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan_4x4 #(
  parameter int SCAN_DIV       = 20000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
      REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_param_check
    $error("keypad_scan_4x4: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD, ST_RELEASE} state_t;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    row_drive = 4'b1110;
      2'd1:    row_drive = 4'b1101;
      2'd2:    row_drive = 4'b1011;
      2'd3:    row_drive = 4'b0111;
      default: row_drive = 4'b1110;
    endcase
  endfunction

  function automatic logic [2:0] count_low(input logic [3:0] v);
    count_low = 3'd0;
    for (int i = 0; i < 4; i++) begin
      count_low = count_low + {2'b00, ~v[i]};
    end
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] v);
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) begin
        first_low = 2'(i);
      end else begin
        first_low = first_low;
      end
    end
  endfunction

  logic [3:0]       col_meta_r, col_sync_r;
  logic [PRE_W-1:0] pre_r;
  logic [1:0]       row_idx_r;
  logic [3:0]       row_r;
  logic [1:0]       hit_r;
  logic [3:0]       first_r;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       cand_r, cand_s;
  logic [3:0]       key_code_r, key_code_s;
  logic             key_valid_r, key_valid_s;
  logic             key_down_r, key_down_s;

  logic             tick_s, end_scan_s;
  logic [2:0]       scan_total_s;
  logic [3:0]       scan_code_s;
  logic             scan_none_s, scan_one_s;
  logic [CNT_W-1:0] cnt_inc_s;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_DONE = REP_W'(REPEAT_SCANS);
  logic [REP_W-1:0] rep_r, rep_s;
`endif

  assign tick_s       = (pre_r == PRE_LAST);
  assign end_scan_s   = tick_s && (row_idx_r == 2'd3);
  assign scan_total_s = {1'b0, hit_r} + count_low(col_sync_r);
  // The first hit of the scan wins; lower rows are visited first.
  assign scan_code_s  = (hit_r == 2'd0) ? {row_idx_r, first_low(col_sync_r)} : first_r;
  assign scan_none_s  = (scan_total_s == 3'd0);
  assign scan_one_s   = (scan_total_s == 3'd1);
  assign cnt_inc_s    = cnt_r + CNT_ONE;

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_r <= 4'b1111;
      col_sync_r <= 4'b1111;
    end else begin
      col_meta_r <= col;
      col_sync_r <= col_meta_r;
    end
  end

  // Row-slot prescaler and row drive walk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r     <= '0;
      row_idx_r <= 2'd0;
      row_r     <= 4'b1110;
    end else if (tick_s) begin
      pre_r     <= '0;
      row_idx_r <= row_idx_r + 2'd1;
      row_r     <= row_drive(row_idx_r + 2'd1);
    end else begin
      pre_r     <= pre_r + PRE_W'(1);
    end
  end

  // Per-scan hit accumulator, saturating at two hits (MULTI).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_r   <= 2'd0;
      first_r <= 4'd0;
    end else if (end_scan_s) begin
      hit_r   <= 2'd0;
      first_r <= 4'd0;
    end else if (tick_s) begin
      hit_r   <= (scan_total_s >= 3'd2) ? 2'd2 : scan_total_s[1:0];
      first_r <= scan_code_s;
    end else begin
      hit_r   <= hit_r;
      first_r <= first_r;
    end
  end

  // Debounce FSM next-state logic, evaluated only on scan completion.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cand_s      = cand_r;
    key_code_s  = key_code_r;
    key_valid_s = 1'b0;
    key_down_s  = key_down_r;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_s       = rep_r;
`endif
    if (end_scan_s) begin
      case (state_r)
        ST_IDLE: begin
          if (scan_one_s) begin
            cand_s = scan_code_s;
            if (CNT_ONE == CNT_DONE) begin
              state_s     = ST_HELD;
              cnt_s       = '0;
              key_code_s  = scan_code_s;
              key_valid_s = 1'b1;
              key_down_s  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_s       = '0;
`endif
            end else begin
              state_s = ST_CONFIRM;
              cnt_s   = CNT_ONE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CONFIRM: begin
          if (scan_one_s && (scan_code_s == cand_r)) begin
            if (cnt_inc_s == CNT_DONE) begin
              state_s     = ST_HELD;
              cnt_s       = '0;
              key_code_s  = cand_r;
              key_valid_s = 1'b1;
              key_down_s  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_s       = '0;
`endif
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            state_s = ST_IDLE;
            cnt_s   = '0;
          end
        end
        ST_HELD: begin
          if (scan_none_s) begin
            if (CNT_ONE == CNT_DONE) begin
              state_s    = ST_IDLE;
              cnt_s      = '0;
              key_down_s = 1'b0;
            end else begin
              state_s = ST_RELEASE;
              cnt_s   = CNT_ONE;
            end
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_r + REP_W'(1) == REP_DONE) begin
              rep_s       = '0;
              key_valid_s = 1'b1;
            end else begin
              rep_s = rep_r + REP_W'(1);
            end
`else
            state_s = ST_HELD;
`endif
          end
        end
        ST_RELEASE: begin
          if (scan_none_s) begin
            if (cnt_inc_s == CNT_DONE) begin
              state_s    = ST_IDLE;
              cnt_s      = '0;
              key_down_s = 1'b0;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            state_s = ST_HELD;
            cnt_s   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_s   = '0;
`endif
          end
        end
        default: begin
          state_s    = ST_IDLE;
          cnt_s      = '0;
          key_down_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Debounce FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      cand_r      <= 4'd0;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_down_r  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_r       <= '0;
`endif
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cand_r      <= cand_s;
      key_code_r  <= key_code_s;
      key_valid_r <= key_valid_s;
      key_down_r  <= key_down_s;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_r       <= rep_s;
`endif
    end
  end

  assign row       = row_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_down  = key_down_r;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4: a key-matrix model drives col from row, a scoreboard queue holds expected strobe codes.
module tb_keypad_scan_4x4;

  localparam int SCAN = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys;

  int          tests = 0;
  int          fails = 0;
  int          strobe_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [3:0]  exp_q[$];

  keypad_scan_4x4 #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(8)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (rst) begin
      if (key_valid) begin
        strobe_cnt <= strobe_cnt + 1;
        check("strobe_width", {31'd0, prev_valid}, 32'd0);
        check("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) check("strobe_code", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
      end
      prev_valid <= key_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic wait_strobe(input int base, input int bound, input string tag);
    for (int i = 0; i < bound && strobe_cnt == base; i++) @(negedge clk);
    @(negedge clk);
    check(tag, strobe_cnt, base + 1);
  endtask

  task automatic wait_down(input logic val, input int bound, input string tag);
    for (int i = 0; i < bound && key_down !== val; i++) @(negedge clk);
    check(tag, {31'd0, key_down}, {31'd0, val});
  endtask

  logic [3:0] walk [4];
  int base;

  initial begin
    walk[0] = 4'b1101; walk[1] = 4'b1011; walk[2] = 4'b0111; walk[3] = 4'b1110;
    rst  = 1'b0;
    keys = 16'd0;
    // 1: reset values, then row walk
    repeat (5) @(negedge clk);
    check("rst_row", {28'd0, row}, 32'h0000000e);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_down", {31'd0, key_down}, 32'd0);
    check("rst_code", {28'd0, key_code}, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge clk);
      check("row_walk", {28'd0, row}, {28'd0, walk[k]});
    end
    // 2: stable press of key 9
    base = strobe_cnt;
    exp_q.push_back(4'd9);
    keys[9] = 1'b1;
    wait_strobe(base, 4*SCAN + 4, "press9_strobe");
    check("press9_code", {28'd0, key_code}, 32'd9);
    check("press9_down", {31'd0, key_down}, 32'd1);
    repeat (2*SCAN) @(negedge clk);
    check("press9_single", strobe_cnt, base + 1);
    // n-key lockout: a second key while 9 is held is ignored
    keys[0] = 1'b1;
    repeat (3*SCAN) @(negedge clk);
    keys[0] = 1'b0;
    check("lockout_down", {31'd0, key_down}, 32'd1);
    // 5a: one-scan release glitch
    keys[9] = 1'b0;
    repeat (SCAN) @(negedge clk);
    keys[9] = 1'b1;
    repeat (4*SCAN) @(negedge clk);
    check("glitch_down", {31'd0, key_down}, 32'd1);
    check("glitch_nostrobe", strobe_cnt, base + 1);
    check("glitch_code", {28'd0, key_code}, 32'd9);
    // 5b: real release
    keys[9] = 1'b0;
    repeat (2*SCAN) @(negedge clk);
    check("release_down_held", {31'd0, key_down}, 32'd1);
    wait_down(1'b0, 4*SCAN, "release_down");
    check("release_nostrobe", strobe_cnt, base + 1);
    check("release_code_kept", {28'd0, key_code}, 32'd9);
    // 3: bouncing contact, then stable
    repeat (3*SCAN) @(negedge clk);
    base = strobe_cnt;
    for (int i = 0; i < 12; i++) begin
      keys[9] = ~keys[9];
      repeat (5) @(negedge clk);
    end
    check("bounce_nostrobe", strobe_cnt, base);
    exp_q.push_back(4'd9);
    keys[9] = 1'b1;
    wait_strobe(base, 5*SCAN, "bounce_strobe");
    check("bounce_down", {31'd0, key_down}, 32'd1);
    keys[9] = 1'b0;
    wait_down(1'b0, 6*SCAN, "bounce_release");
    // 4: two keys together
    repeat (2*SCAN) @(negedge clk);
    base = strobe_cnt;
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    repeat (6*SCAN) @(negedge clk);
    check("multi_nostrobe", strobe_cnt, base);
    check("multi_down", {31'd0, key_down}, 32'd0);
    keys = 16'd0;
    repeat (3*SCAN) @(negedge clk);
    // 6: reset while confirming key 9
    base = strobe_cnt;
    keys[9] = 1'b1;
    repeat (SCAN + SCAN/2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_row", {28'd0, row}, 32'h0000000e);
    check("midrst_valid", {31'd0, key_valid}, 32'd0);
    check("midrst_down", {31'd0, key_down}, 32'd0);
    check("midrst_code", {28'd0, key_code}, 32'd0);
    keys = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5*SCAN) @(negedge clk);
    check("midrst_nostrobe", strobe_cnt, base);
    check("midrst_down_after", {31'd0, key_down}, 32'd0);
`ifdef KEYPAD_AUTOREPEAT_EN
    // 7: auto-repeat of key 3
    base = strobe_cnt;
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd3);
    keys[3] = 1'b1;
    repeat (25*SCAN) @(negedge clk);
    check("repeat_count", strobe_cnt, base + 3);
    keys[3] = 1'b0;
    wait_down(1'b0, 6*SCAN, "repeat_release");
    check("repeat_after_release", strobe_cnt, base + 3);
`endif
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
